uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 143 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM state type and defaults for the UART transmit arbiter
package uart_pkg;

  localparam int DATA_W_DEF       = 8;
  localparam int BUSY_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_t;

  // Index width for n requesters; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after the last grant
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  // Walk from the farthest candidate to the nearest so the nearest requester after last_grant wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int off = N_REQ; off >= 1; off--) begin
      idx = (int'(last_grant) + off) % N_REQ;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - shares one UART transmitter among N_REQ byte requesters
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF,
  localparam int IDX_W = idx_width(N_REQ),
  localparam int CNT_W = $clog2(BUSY_TIMEOUT) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_lock,
  output logic [N_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]       tx_data,
  output logic                    tx_start,
  input  logic                    tx_busy,
  output logic [IDX_W-1:0]        grant_id,
  output logic                    arb_busy,
  output logic                    err_timeout
);

  arb_state_t        state;
  logic [IDX_W-1:0]  last_grant;
  logic              lock;
  logic [CNT_W-1:0]  cnt;

  logic [N_REQ-1:0]  rr_grant;
  logic [IDX_W-1:0]  rr_idx;
  logic              rr_any;

  logic              idle_accept;
  logic              cont_accept;
  logic [IDX_W-1:0]  pick_idx;
  logic [DATA_W-1:0] pick_data;
  logic              pick_lock;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (rr_grant),
    .grant_idx  (rr_idx),
    .any        (rr_any)
  );

  // Decide whether a byte is taken this cycle: fresh arbitration in IDLE, or a locked frame continuing.
  always_comb begin
    idle_accept = (state == ST_IDLE) && rr_any;
    cont_accept = (state == ST_WAIT_DONE) && !tx_busy && lock && req_valid[grant_id];
    pick_idx    = (state == ST_IDLE) ? rr_idx : grant_id;
  end

  // Mux out the byte and lock flag of whichever requester is being accepted.
  always_comb begin
    pick_data = '0;
    pick_lock = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IDX_W'(i) == pick_idx) begin
        pick_data = req_data[i*DATA_W +: DATA_W];
        pick_lock = req_lock[i];
      end
    end
  end

  // Accept handshake is same-cycle with the decision, so it cannot be registered; reset masks it.
  always_comb begin
    req_ready = '0;
    if (!rst) begin
      if (idle_accept) begin
        req_ready = rr_grant;
      end else if (cont_accept) begin
        req_ready[grant_id] = 1'b1;
      end
    end
  end

  // Arbitration FSM; tx_start and arb_busy are registered on entry to the states that own them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      grant_id    <= '0;
      arb_busy    <= 1'b0;
      err_timeout <= 1'b0;
      cnt         <= '0;
      lock        <= 1'b0;
      last_grant  <= IDX_W'(N_REQ - 1);
    end else begin
      tx_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (idle_accept) begin
            tx_data  <= pick_data;
            lock     <= pick_lock;
            grant_id <= rr_idx;
            tx_start <= 1'b1;
            arb_busy <= 1'b1;
            state    <= ST_START;
          end
        end
        ST_START: begin
          cnt   <= '0;
          state <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (tx_busy) begin
            state <= ST_WAIT_DONE;
          end else if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
            // Transmitter never answered: flag it, drop the byte and rotate past this requester.
            err_timeout <= 1'b1;
            last_grant  <= grant_id;
            arb_busy    <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy) begin
            if (cont_accept) begin
              tx_data  <= pick_data;
              lock     <= pick_lock;
              tx_start <= 1'b1;
              state    <= ST_START;
            end else begin
              last_grant <= grant_id;
              arb_busy   <= 1'b0;
              state      <= ST_IDLE;
            end
          end
        end
        default: begin
          arb_busy <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int BL  = 10;

  typedef struct packed { logic [7:0] d; logic l; } pkt_t;
  typedef struct packed { logic [7:0] d; logic [1:0] g; } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]  req_lock = '0;
  logic [N-1:0]  req_ready;
  logic [DW-1:0] tx_data;
  logic          tx_start;
  logic          tx_busy = 1'b0;
  logic [1:0]    grant_id;
  logic          arb_busy;
  logic          err_timeout;

  pkt_t pq[N][$];
  exp_t sb[$];
  logic [N-1:0] acc = '0;
  logic tx_en = 1'b1;
  int   tx_cnt = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  uart_tx_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_lock(req_lock), .req_ready(req_ready), .tx_data(tx_data),
    .tx_start(tx_start), .tx_busy(tx_busy), .grant_id(grant_id),
    .arb_busy(arb_busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Requesters: pop a byte after it was accepted, then present the next head of each queue.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++)
      if (acc[i] && pq[i].size() > 0) void'(pq[i].pop_front());
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (pq[i].size() > 0);
      req_data[i*DW +: DW] = (pq[i].size() > 0) ? pq[i][0].d : 8'h00;
      req_lock[i] = (pq[i].size() > 0) ? pq[i][0].l : 1'b0;
    end
    #3;
    acc = req_ready;
  end

  // Transmitter model: busy for BL cycles starting the cycle after tx_start.
  always @(negedge clk) begin
    if (rst) begin
      tx_busy = 1'b0;
      tx_cnt  = 0;
    end else begin
      if (tx_cnt != 0) begin
        tx_busy = 1'b1;
        tx_cnt--;
      end else begin
        tx_busy = 1'b0;
      end
      if (tx_start && tx_en) tx_cnt = BL;
    end
  end

  // Monitor: every tx_start must match the next expected byte and follow a one-hot accept.
  always @(negedge clk) begin
    if (!rst && tx_start) begin
      if (sb.size() == 0) begin
        check("unexpected_tx_start", {24'h0, tx_data}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("tx_data", {24'h0, tx_data}, {24'h0, e.d});
        check("grant_id", {30'h0, grant_id}, {30'h0, e.g});
        check("ready_before_start", {28'h0, acc}, 32'h1 << e.g);
        check("ready_in_start", {28'h0, req_ready}, 32'h0);
      end
    end
  end

  task automatic push(input int r, input logic [7:0] d, input logic l);
    pkt_t p;
    p.d = d; p.l = l;
    pq[r].push_back(p);
  endtask

  task automatic expect_tx(input logic [7:0] d, input logic [1:0] g);
    exp_t e;
    e.d = d; e.g = g;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while (k < budget && !(sb.size() == 0 && req_valid == '0 && !arb_busy && !tx_busy)) begin
      @(negedge clk);
      k++;
    end
    check(name, {31'h0, k >= budget}, 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_start"}, {31'h0, tx_start}, 32'h0);
    check({tag, "_tx_data"}, {24'h0, tx_data}, 32'h0);
    check({tag, "_req_ready"}, {28'h0, req_ready}, 32'h0);
    check({tag, "_grant_id"}, {30'h0, grant_id}, 32'h0);
    check({tag, "_arb_busy"}, {31'h0, arb_busy}, 32'h0);
    check({tag, "_err_timeout"}, {31'h0, err_timeout}, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;

    // Single byte from requester 0 after reset.
    @(negedge clk);
    push(0, 8'h05, 1'b0);
    expect_tx(8'h05, 2'd0);
    wait_idle("idle_single", 200);

    // All four requesters valid, no locks: rotation 0,1,2,3 then 0 again.
    do_reset();
    @(negedge clk);
    push(0, 8'hA0, 1'b0); push(1, 8'hA1, 1'b0);
    push(2, 8'hA2, 1'b0); push(3, 8'hA3, 1'b0);
    push(0, 8'hA0, 1'b0);
    expect_tx(8'hA0, 2'd0); expect_tx(8'hA1, 2'd1);
    expect_tx(8'hA2, 2'd2); expect_tx(8'hA3, 2'd3);
    expect_tx(8'hA0, 2'd0);
    wait_idle("idle_rotate", 500);

    // Locked three-byte frame from requester 2 keeps out requester 1 until it ends.
    @(negedge clk);
    push(2, 8'h11, 1'b1); push(2, 8'h22, 1'b1); push(2, 8'h33, 1'b1);
    expect_tx(8'h11, 2'd2); expect_tx(8'h22, 2'd2); expect_tx(8'h33, 2'd2);
    expect_tx(8'h44, 2'd1);
    repeat (3) @(negedge clk);
    push(1, 8'h44, 1'b0);
    wait_idle("idle_lock", 500);

    // Transmitter never goes busy: timeout after 16 waiting cycles, then recovery.
    tx_en = 1'b0;
    @(negedge clk);
    push(3, 8'h5A, 1'b0);
    expect_tx(8'h5A, 2'd3);
    k = 0;
    while (k < 50 && !tx_start) begin
      @(negedge clk);
      k++;
    end
    check("timeout_start_seen", {31'h0, k >= 50}, 32'h0);
    repeat (16) @(negedge clk);
    check("err_before_limit", {31'h0, err_timeout}, 32'h0);
    check("busy_before_limit", {31'h0, arb_busy}, 32'h1);
    @(negedge clk);
    check("err_at_limit", {31'h0, err_timeout}, 32'h1);
    check("idle_after_timeout", {31'h0, arb_busy}, 32'h0);
    tx_en = 1'b1;
    push(0, 8'h77, 1'b0);
    expect_tx(8'h77, 2'd0);
    wait_idle("idle_after_timeout", 200);
    check("err_sticky", {31'h0, err_timeout}, 32'h1);

    // Reset while the transmitter is busy aborts the frame; requester 0 wins afterwards.
    push(1, 8'h99, 1'b0);
    expect_tx(8'h99, 2'd1);
    k = 0;
    while (k < 50 && !tx_busy) begin
      @(negedge clk);
      k++;
    end
    check("busy_seen", {31'h0, k >= 50}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("midrst");
    wait_idle("idle_after_midrst", 200);
    push(0, 8'hAA, 1'b0); push(2, 8'hBB, 1'b0);
    expect_tx(8'hAA, 2'd0); expect_tx(8'hBB, 2'd2);
    wait_idle("idle_final", 300);
    check("scoreboard_empty", sb.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
